// File: rtl/rt_pkg.sv
// -----------------------------------------------------------------------------
// rt_pkg
//   Types shared by the ray-sphere pipeline stages.
//   - RT_CW       : default coordinate width
//   - coord_t     : signed coordinate
//   - vec3_t      : {x, y, z} vector of coordinates
//   - ray_t       : {start, dir} primary ray
//   - gen_state_e : pixel_ray_generator control states
// -----------------------------------------------------------------------------
package rt_pkg;

  localparam int RT_CW = 16;

  typedef logic signed [RT_CW-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t z;
  } vec3_t;

  typedef struct packed {
    vec3_t start;
    vec3_t dir;
  } ray_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    DRAIN = 2'd2
  } gen_state_e;

endpackage

// File: rtl/raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
//   Column/row counter walking an IMG_W x IMG_H grid in raster order.
//   Ports:
//     clk        : clock, rising edge
//     rst_n      : asynchronous active-low reset (counters -> 0)
//     i_clear    : synchronous clear to (0,0); wins over i_advance
//     i_advance  : step to the next pixel; the last pixel wraps to (0,0)
//     o_px/o_py  : current column / row
//     o_last_px  : current column is IMG_W-1
//     o_last_pix : current pixel is the last one of the frame
// -----------------------------------------------------------------------------
module raster_counter #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_advance,
  output logic [15:0] o_px,
  output logic [15:0] o_py,
  output logic        o_last_px,
  output logic        o_last_pix
);

  localparam logic [15:0] L_LAST_X = 16'(IMG_W - 1);
  localparam logic [15:0] L_LAST_Y = 16'(IMG_H - 1);

  logic [15:0] r_px;
  logic [15:0] r_py;
  logic [15:0] w_px_next;
  logic [15:0] w_py_next;

  assign o_last_px  = (r_px == L_LAST_X);
  assign o_last_pix = o_last_px && (r_py == L_LAST_Y);

  always_comb begin
    w_px_next = r_px;
    w_py_next = r_py;
    if (i_clear) begin
      w_px_next = '0;
      w_py_next = '0;
    end else if (i_advance) begin
      if (o_last_px) begin
        w_px_next = '0;
        // Wrapping the row after the final pixel leaves the counter ready
        // for the next frame at (0,0).
        w_py_next = o_last_pix ? 16'd0 : r_py + 16'd1;
      end else begin
        w_px_next = r_px + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_px <= '0;
      r_py <= '0;
    end else begin
      r_px <= w_px_next;
      r_py <= w_py_next;
    end
  end

  assign o_px = r_px;
  assign o_py = r_py;

endmodule

// File: rtl/pixel_ray_generator.sv
// -----------------------------------------------------------------------------
// pixel_ray_generator
//   Walks an IMG_W x IMG_H pixel grid in raster order and emits one primary
//   ray per pixel over a valid/ready handshake. The camera origin is latched
//   on start; a completed frame ends with a one-cycle frame_done pulse.
//   Ports:
//     ACLK, ARESETn            : clock / asynchronous active-low reset
//     start                    : begin a frame (only honoured in IDLE)
//     abort                    : drop the current frame, back to IDLE
//     origin_x/y/z             : camera origin, sampled on the start cycle
//     ray_valid / ray_ready    : output handshake
//     ray_start_x/y/z          : latched origin
//     ray_dir_x/y/z            : per-pixel direction
//     pix_x / pix_y            : column / row of the current ray
//     busy                     : high while emitting or draining
//     frame_done               : pulse after the last pixel is accepted
// -----------------------------------------------------------------------------
module pixel_ray_generator
  import rt_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 48,
  parameter int FOCAL = 64,
  parameter int CW    = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 start,
  input  logic                 abort,
  input  logic signed [CW-1:0] origin_x,
  input  logic signed [CW-1:0] origin_y,
  input  logic signed [CW-1:0] origin_z,
  output logic                 ray_valid,
  input  logic                 ray_ready,
  output logic signed [CW-1:0] ray_start_x,
  output logic signed [CW-1:0] ray_start_y,
  output logic signed [CW-1:0] ray_start_z,
  output logic signed [CW-1:0] ray_dir_x,
  output logic signed [CW-1:0] ray_dir_y,
  output logic signed [CW-1:0] ray_dir_z,
  output logic [15:0]          pix_x,
  output logic [15:0]          pix_y,
  output logic                 busy,
  output logic                 frame_done
);

  // Direction of pixel (0,0); evaluated one bit wider, then truncated.
  localparam logic signed [CW:0]   L_HALF_W_WIDE = (CW+1)'(IMG_W / 2);
  localparam logic signed [CW:0]   L_HALF_H_WIDE = (CW+1)'(IMG_H / 2);
  localparam logic signed [CW:0]   L_NEG_F_WIDE  = (CW+1)'(-FOCAL);
  localparam logic signed [CW:0]   L_DIR0_X_WIDE = -L_HALF_W_WIDE;
  localparam logic signed [CW-1:0] L_DIR0_X      = L_DIR0_X_WIDE[CW-1:0];
  localparam logic signed [CW-1:0] L_DIR0_Y      = L_HALF_H_WIDE[CW-1:0];
  localparam logic signed [CW-1:0] L_DIR_Z       = L_NEG_F_WIDE[CW-1:0];

  gen_state_e r_state;
  gen_state_e w_state_next;

  logic                 r_ray_valid;
  logic                 r_busy;
  logic                 r_frame_done;
  logic signed [CW-1:0] r_start_x;
  logic signed [CW-1:0] r_start_y;
  logic signed [CW-1:0] r_start_z;
  logic signed [CW-1:0] r_dir_x;
  logic signed [CW-1:0] r_dir_y;
  logic signed [CW-1:0] r_dir_z;

  logic        w_hs;
  logic        w_start_acc;
  logic        w_clear;
  logic        w_advance;
  logic [15:0] w_px;
  logic [15:0] w_py;
  logic        w_last_px;
  logic        w_last_pix;

  // ray_valid is high exactly in EMIT, so it doubles as the state qualifier.
  assign w_hs        = r_ray_valid && ray_ready;
  assign w_start_acc = (r_state == IDLE) && start && !abort;
  assign w_clear     = abort || w_start_acc;
  assign w_advance   = w_hs && !abort;

  raster_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_raster_counter (
    .clk        (ACLK),
    .rst_n      (ARESETn),
    .i_clear    (w_clear),
    .i_advance  (w_advance),
    .o_px       (w_px),
    .o_py       (w_py),
    .o_last_px  (w_last_px),
    .o_last_pix (w_last_pix)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_start_acc) w_state_next = EMIT;
      end
      EMIT: begin
        if (abort)                   w_state_next = IDLE;
        else if (w_hs && w_last_pix) w_state_next = DRAIN;
      end
      DRAIN: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state      <= IDLE;
      r_ray_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_start_x    <= '0;
      r_start_y    <= '0;
      r_start_z    <= '0;
      r_dir_x      <= '0;
      r_dir_y      <= '0;
      r_dir_z      <= '0;
    end else begin
      r_state      <= w_state_next;
      // Status outputs are registered copies of the next state.
      r_ray_valid  <= (w_state_next == EMIT);
      r_busy       <= (w_state_next == EMIT) || (w_state_next == DRAIN);
      r_frame_done <= (w_state_next == DRAIN);

      if (w_start_acc) begin
        r_start_x <= origin_x;
        r_start_y <= origin_y;
        r_start_z <= origin_z;
        r_dir_x   <= L_DIR0_X;
        r_dir_y   <= L_DIR0_Y;
        r_dir_z   <= L_DIR_Z;
      end else if (w_advance && !w_last_pix) begin
        // Stepping incrementally keeps dir_x = px - W/2 and dir_y = H/2 - py
        // in lock-step with the counter, without a subtractor per axis.
        if (w_last_px) begin
          r_dir_x <= L_DIR0_X;
          r_dir_y <= r_dir_y - 1'b1;
        end else begin
          r_dir_x <= r_dir_x + 1'b1;
        end
      end
    end
  end

  assign ray_valid   = r_ray_valid;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign ray_start_x = r_start_x;
  assign ray_start_y = r_start_y;
  assign ray_start_z = r_start_z;
  assign ray_dir_x   = r_dir_x;
  assign ray_dir_y   = r_dir_y;
  assign ray_dir_z   = r_dir_z;
  assign pix_x       = w_px;
  assign pix_y       = w_py;

endmodule

// File: tb/tb_pixel_ray_generator.sv
// -----------------------------------------------------------------------------
// tb_pixel_ray_generator
//   Directed and randomized stimulus for pixel_ray_generator (4x2 grid,
//   focal 8). A frame-level reference model (pixel index k, active/done
//   flags, latched origin) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_pixel_ray_generator;

  localparam int W = 4;
  localparam int H = 2;
  localparam int F = 8;

  logic               ACLK;
  logic               ARESETn;
  logic               start;
  logic               abort;
  logic signed [15:0] origin_x;
  logic signed [15:0] origin_y;
  logic signed [15:0] origin_z;
  logic               ray_valid;
  logic               ray_ready;
  logic signed [15:0] ray_start_x;
  logic signed [15:0] ray_start_y;
  logic signed [15:0] ray_start_z;
  logic signed [15:0] ray_dir_x;
  logic signed [15:0] ray_dir_y;
  logic signed [15:0] ray_dir_z;
  logic [15:0]        pix_x;
  logic [15:0]        pix_y;
  logic               busy;
  logic               frame_done;

  pixel_ray_generator #(
    .IMG_W (W),
    .IMG_H (H),
    .FOCAL (F),
    .CW    (16)
  ) dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .start       (start),
    .abort       (abort),
    .origin_x    (origin_x),
    .origin_y    (origin_y),
    .origin_z    (origin_z),
    .ray_valid   (ray_valid),
    .ray_ready   (ray_ready),
    .ray_start_x (ray_start_x),
    .ray_start_y (ray_start_y),
    .ray_start_z (ray_start_z),
    .ray_dir_x   (ray_dir_x),
    .ray_dir_y   (ray_dir_y),
    .ray_dir_z   (ray_dir_z),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a frame is either in progress (m_active, next pixel
  // index m_k in raster order) or has just completed (m_done for one cycle).
  bit                 m_active;
  bit                 m_done;
  int                 m_k;
  logic signed [15:0] m_ox;
  logic signed [15:0] m_oy;
  logic signed [15:0] m_oz;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_k      = 0;
  endtask

  task automatic check_zero(input string tag);
    chk1({tag, "_valid"}, ray_valid, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, frame_done, 1'b0);
    chk({tag, "_start_x"}, ray_start_x, 16'h0000);
    chk({tag, "_start_y"}, ray_start_y, 16'h0000);
    chk({tag, "_start_z"}, ray_start_z, 16'h0000);
    chk({tag, "_dir_x"}, ray_dir_x, 16'h0000);
    chk({tag, "_dir_y"}, ray_dir_y, 16'h0000);
    chk({tag, "_dir_z"}, ray_dir_z, 16'h0000);
    chk({tag, "_pix_x"}, pix_x, 16'h0000);
    chk({tag, "_pix_y"}, pix_y, 16'h0000);
  endtask

  task automatic check_outputs();
    chk1("ray_valid", ray_valid, m_active);
    chk1("frame_done", frame_done, m_done);
    chk1("busy", busy, m_active || m_done);
    if (m_active) begin
      chk("pix_x", pix_x, 16'(m_k % W));
      chk("pix_y", pix_y, 16'(m_k / W));
      chk("dir_x", ray_dir_x, 16'((m_k % W) - W / 2));
      chk("dir_y", ray_dir_y, 16'(H / 2 - m_k / W));
      chk("dir_z", ray_dir_z, 16'(-F));
      chk("start_x", ray_start_x, m_ox);
      chk("start_y", ray_start_y, m_oy);
      chk("start_z", ray_start_z, m_oz);
    end else begin
      chk("idle_pix_x", pix_x, 16'h0000);
      chk("idle_pix_y", pix_y, 16'h0000);
    end
  endtask

  task automatic model_update(input bit st, input bit ab, input bit rdy);
    if (m_active) begin
      if (ab) begin
        m_active = 1'b0;
        $display("[TB] abort at pixel %0d", m_k);
      end else if (rdy) begin
        $display("[TB] ray accepted k=%0d pix=(%0d,%0d)", m_k, m_k % W, m_k / W);
        m_k++;
        if (m_k == W * H) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (st && !ab) begin
      m_active = 1'b1;
      m_k      = 0;
      m_ox     = origin_x;
      m_oy     = origin_y;
      m_oz     = origin_z;
      $display("[TB] frame start origin=(%0d,%0d,%0d)", m_ox, m_oy, m_oz);
    end
  endtask

  // Called at a falling edge: check, drive, clock, advance the model.
  task automatic cycle(input bit st, input bit ab, input bit rdy);
    check_outputs();
    start     = st;
    abort     = ab;
    ray_ready = rdy;
    @(posedge ACLK);
    model_update(st, ab, rdy);
    @(negedge ACLK);
  endtask

  task automatic set_origin(input int x, input int y, input int z);
    origin_x = 16'(x);
    origin_y = 16'(y);
    origin_z = 16'(z);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the end of the run");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETn   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    ray_ready = 1'b0;
    set_origin(0, 0, 0);
    model_reset();
    repeat (2) @(negedge ACLK);
    check_zero("reset");
    ARESETn = 1'b1;
    check_zero("release");
    cycle(0, 0, 1);

    // 1: full frame, ready held high
    set_origin(0, 10, 0);
    cycle(1, 0, 1);
    repeat (W * H + 2) cycle(0, 0, 1);

    // 2: stall three cycles on pixel 2
    cycle(1, 0, 1);
    repeat (2) cycle(0, 0, 1);
    repeat (3) cycle(0, 0, 0);
    repeat (W * H) cycle(0, 0, 1);

    // 3: second start mid-frame with a different origin is ignored
    cycle(1, 0, 1);
    repeat (2) cycle(0, 0, 1);
    set_origin(5, 5, 5);
    cycle(1, 0, 1);
    cycle(1, 0, 0);
    repeat (W * H) cycle(0, 0, 1);
    set_origin(0, 10, 0);

    // 4: abort together with the handshake on pixel 5, then a fresh frame
    cycle(1, 0, 1);
    repeat (5) cycle(0, 0, 1);
    cycle(0, 1, 1);
    repeat (2) cycle(0, 0, 1);
    cycle(1, 0, 1);
    repeat (W * H + 1) cycle(0, 0, 1);

    // start and abort together while idle: stay idle
    cycle(1, 1, 1);
    repeat (2) cycle(0, 0, 1);

    // 5: asynchronous reset at pixel 3
    cycle(1, 0, 1);
    repeat (3) cycle(0, 0, 1);
    check_outputs();
    #2 ARESETn = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    @(negedge ACLK);
    @(negedge ACLK);
    check_zero("held_rst");
    ARESETn = 1'b1;
    cycle(0, 0, 1);
    cycle(1, 0, 1);
    repeat (W * H + 1) cycle(0, 0, 1);

    // 6: extreme origin values are echoed bit-exactly
    set_origin(-1, -32768, 32767);
    cycle(1, 0, 1);
    chk("org6_x", ray_start_x, 16'hFFFF);
    chk("org6_y", ray_start_y, 16'h8000);
    chk("org6_z", ray_start_z, 16'h7FFF);
    repeat (W * H + 1) cycle(0, 0, 1);

    // Randomized traffic: random ready, start pulses, origins, rare aborts
    for (int i = 0; i < 800; i++) begin
      bit st;
      bit ab;
      bit rdy;
      st  = ($urandom_range(0, 3) == 0);
      ab  = ($urandom_range(0, 59) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      if (!m_active) begin
        origin_x = 16'($urandom);
        origin_y = 16'($urandom);
        origin_z = 16'($urandom);
      end
      cycle(st, ab, rdy);
    end
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
